codificador_instrucciones: RTL and testbench
============================================

# codificador_instrucciones

Sequential MIPS instruction encoder and program loader: accepts one instruction per handshake as mnemonic selector plus fields, encodes it into the 32-bit MIPS word that the control-unit decoder consumes (opcode/funct), and writes it into instruction memory at consecutive word addresses. It sits between the test/boot loader and the instruction memory write port. It fills memory up to DEPTH words, then reports full and records overflow attempts.

## Interface
- DEPTH, 64, maximum number of instructions written before full
- BASE_ADDR, 32'h0000_0000, byte address of the first written word (word-aligned)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous restart: address back to BASE_ADDR, count and overflow to 0
- in_valid  input  1  instruction fields valid
- in_ready  output  1  encoder can accept this cycle
- op_sel  input  4  mnemonic: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 jal, 6 addi, 7 ori, 8 andi, 9 slti, 10 lw, 11 sw, 12 beq, 13 bne, 14 bgtz, 15 j
- rs, rt, rd  input  5 each  register fields
- imm  input  16  immediate / branch offset, passed unmodified
- target  input  26  jump target field
- mem_we  output  1  instruction memory write strobe
- mem_addr  output  32  byte address of the write
- mem_wdata  output  32  encoded instruction word
- count  output  $clog2(DEPTH+1)  words written since reset/clear
- full  output  1  count == DEPTH
- overflow  output  1  sticky: in_valid seen while full

## Operation
- Encoding (combinational from fields, registered at accept):
  - R-type (0–4): {6'b000000, rs, rt, rd, 5'b00000, funct}, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - I-type: {opcode, rs, rt, imm}, with opcode addi 001000, ori 001101, andi 001100, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101, bgtz 000111.
  - bgtz forces the rt field to 00000 regardless of input.
  - J-type: {opcode, target}, with opcode j 000010, jal 000011. rs/rt/rd/imm are ignored.
- States:
  - S_IDLE:
    - in_ready = !full.
    - Accept (in_valid && in_ready) latches the encoded word into word_q and moves to S_WRITE.
    - in_valid && full sets overflow; state stays S_IDLE.
  - S_WRITE:
    - in_ready = 0, mem_we = 1, mem_addr = addr_q, mem_wdata = word_q.
    - At the next edge: addr_q += 4, count += 1, return to S_IDLE.
- full is derived from count. Once full, no further writes until clear.
- clear:
  - In S_IDLE, clear has priority over accept. No accept occurs that cycle; addr_q = BASE_ADDR, count = 0, overflow = 0.
  - In S_WRITE, the write strobe of that cycle is still issued. At the edge, clear wins over the increment: addr_q = BASE_ADDR, count = 0, state goes to S_IDLE.
- addr_q never wraps: at most DEPTH increments occur, and addr_q is 32 bits.

## Timing
- Reset (rst_n low, asynchronous) sets the following. Outputs settle without a clock edge.
  - state = S_IDLE
  - in_ready = 1 (if DEPTH > 0)
  - mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0
  - count = 0, full = 0, overflow = 0
- Latency: accept at edge N → mem_we high for exactly cycle N..N+1 → count updates at edge N+1.
- Throughput: one instruction per 2 cycles. in_ready is low during S_WRITE.
- mem_wdata and mem_addr are registered and stable for the whole mem_we cycle. mem_wdata holds its last value when mem_we = 0.
- Fields only need to be valid in the accept cycle.
- in_valid during S_WRITE is not accepted and does not set overflow. The source holds in_valid until it sees in_ready.
- rst_n asserted mid-write aborts immediately: mem_we drops asynchronously and count does not increment.

## Test plan
- Reset, then add rs=1 rt=2 rd=3 → mem_we one cycle at mem_addr 0x00000000 with wdata 0x00221820; count=1.
- Back-to-back addi rs=0 rt=8 imm=0xFFFF, then lw rs=29 rt=8 imm=4, with in_valid held → words 0x2008FFFF at addr 0x0 and 0x8FA80004 at addr 0x4, two cycles apart; in_ready low during each write.
- Send j target=0x0000010, jal target=0x0000010, and bgtz rs=4 rt=7 imm=3 → 0x08000010, 0x0C000010, and 0x1C800003 (rt forced to 0).
- DEPTH=4: write 4 instructions, then hold in_valid → full=1, in_ready=0, no mem_we, overflow=1. Then clear → count=0, overflow=0, next write goes to BASE_ADDR.
- Assert clear in the S_WRITE cycle of the 3rd word → that write is still issued at addr 0x8; the next accepted word is written at 0x0 and count=1.
- Pulse rst_n low during S_WRITE → mem_we falls without a clock edge; count, mem_addr, and state return to their reset values.

Source files
------------

// File: rtl/codificador_instrucciones_if.sv
// Loader-side bus of the instruction encoder: handshake, instruction fields,
// memory write port and fill status.
interface codificador_instrucciones_if #(
  parameter int DEPTH = 64
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op_sel;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;

  modport master (
    output clear, in_valid, op_sel, rs, rt, rd, imm, target,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, overflow
  );

  modport slave (
    input  clear, in_valid, op_sel, rs, rt, rd, imm, target,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, overflow
  );
endinterface

// File: rtl/codificador_instrucciones.sv
// MIPS instruction encoder and program loader: encodes one instruction per
// handshake and writes it to instruction memory at consecutive word addresses.
//
// state   | meaning
// S_IDLE  | waiting for an instruction; ready unless memory is full
// S_WRITE | write strobe high for the word latched at accept
module codificador_instrucciones #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  codificador_instrucciones_if.slave bus
);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t        r_state;
  logic [31:0]   r_word;
  logic [31:0]   r_addr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_mem_we;

  logic [31:0]   w_word;
  logic          w_full;
  logic          w_ready;

  function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opcode, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opcode, rs, rt, imm};
  endfunction

  always_comb begin
    w_word = '0;
    case (bus.op_sel)
      4'd0:  w_word = enc_r(FN_ADD, bus.rs, bus.rt, bus.rd);
      4'd1:  w_word = enc_r(FN_SUB, bus.rs, bus.rt, bus.rd);
      4'd2:  w_word = enc_r(FN_AND, bus.rs, bus.rt, bus.rd);
      4'd3:  w_word = enc_r(FN_OR,  bus.rs, bus.rt, bus.rd);
      4'd4:  w_word = enc_r(FN_SLT, bus.rs, bus.rt, bus.rd);
      4'd5:  w_word = {OP_JAL, bus.target};
      4'd6:  w_word = enc_i(OP_ADDI, bus.rs, bus.rt, bus.imm);
      4'd7:  w_word = enc_i(OP_ORI,  bus.rs, bus.rt, bus.imm);
      4'd8:  w_word = enc_i(OP_ANDI, bus.rs, bus.rt, bus.imm);
      4'd9:  w_word = enc_i(OP_SLTI, bus.rs, bus.rt, bus.imm);
      4'd10: w_word = enc_i(OP_LW,   bus.rs, bus.rt, bus.imm);
      4'd11: w_word = enc_i(OP_SW,   bus.rs, bus.rt, bus.imm);
      4'd12: w_word = enc_i(OP_BEQ,  bus.rs, bus.rt, bus.imm);
      4'd13: w_word = enc_i(OP_BNE,  bus.rs, bus.rt, bus.imm);
      // bgtz has no second source register; rt is architecturally zero
      4'd14: w_word = enc_i(OP_BGTZ, bus.rs, 5'b00000, bus.imm);
      4'd15: w_word = {OP_J, bus.target};
    endcase
  end

  assign w_full  = (r_count == DEPTH_C);
  assign w_ready = (r_state == S_IDLE) && !w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_addr     <= BASE_ADDR;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_mem_we   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.clear) begin
            r_addr     <= BASE_ADDR;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end else if (bus.in_valid && w_ready) begin
            r_word   <= w_word;
            r_mem_we <= 1'b1;
            r_state  <= S_WRITE;
          end else if (bus.in_valid && w_full) begin
            r_overflow <= 1'b1;
          end
        end
        S_WRITE: begin
          r_mem_we <= 1'b0;
          r_state  <= S_IDLE;
          // the strobe of this cycle still goes out; clear only wins the increment
          if (bus.clear) begin
            r_addr     <= BASE_ADDR;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end else begin
            r_addr  <= r_addr + 32'd4;
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_mem_we <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_word;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_codificador_instrucciones.sv
// Directed bench for the instruction encoder: a DEPTH=64 instance for encoding
// and sequencing, and a DEPTH=4 instance for full/overflow behaviour.
module tb_codificador_instrucciones;
  logic clk;
  logic rst_n;

  logic        v_valid, v_valid4, v_clear, v_clear4;
  logic [3:0]  v_op;
  logic [4:0]  v_rs, v_rt, v_rd;
  logic [15:0] v_imm;
  logic [25:0] v_tgt;

  int n_checks;
  int n_fail;
  logic [31:0] all_exp [16];

  codificador_instrucciones_if #(.DEPTH(64)) bus ();
  codificador_instrucciones_if #(.DEPTH(4))  bus4 ();

  assign bus.clear     = v_clear;
  assign bus.in_valid  = v_valid;
  assign bus.op_sel    = v_op;
  assign bus.rs        = v_rs;
  assign bus.rt        = v_rt;
  assign bus.rd        = v_rd;
  assign bus.imm       = v_imm;
  assign bus.target    = v_tgt;
  assign bus4.clear    = v_clear4;
  assign bus4.in_valid = v_valid4;
  assign bus4.op_sel   = v_op;
  assign bus4.rs       = v_rs;
  assign bus4.rt       = v_rt;
  assign bus4.rd       = v_rd;
  assign bus4.imm      = v_imm;
  assign bus4.target   = v_tgt;

  codificador_instrucciones #(.DEPTH(64), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  codificador_instrucciones #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  always #5 clk = ~clk;

  task automatic set_fields(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    v_op = op; v_rs = rs; v_rt = rt; v_rd = rd; v_imm = imm; v_tgt = tgt;
  endtask

  // one-cycle valid pulse on the main instance; returns 1ns after the accept edge
  task automatic pulse_valid();
    @(negedge clk); v_valid = 1'b1;
    @(posedge clk); #1 v_valid = 1'b0;
  endtask

  task automatic pulse_valid4();
    @(negedge clk); v_valid4 = 1'b1;
    @(posedge clk); #1 v_valid4 = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); v_clear = 1'b1;
    @(posedge clk); #1 v_clear = 1'b0;
  endtask

  task automatic next_edge();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", bus.mem_wdata); end
    n_checks++; if (bus.count !== 7'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", bus.full); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", bus.overflow); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    set_fields(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    pulse_valid();
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL add_we got %b exp 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL add_addr got %h exp 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h0022_1820) begin n_fail++; $display("FAIL add_wdata got %h exp 00221820", bus.mem_wdata); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL add_ready_w got %b exp 0", bus.in_ready); end
    n_checks++; if (bus.count !== 7'd0) begin n_fail++; $display("FAIL add_count_w got %0d exp 0", bus.count); end
    next_edge();
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL add_we_off got %b exp 0", bus.mem_we); end
    n_checks++; if (bus.count !== 7'd1) begin n_fail++; $display("FAIL add_count got %0d exp 1", bus.count); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (bus.mem_wdata !== 32'h0022_1820) begin n_fail++; $display("FAIL add_wdata_hold got %h exp 00221820", bus.mem_wdata); end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    n_checks++; if (bus.count !== 7'd0) begin n_fail++; $display("FAIL b2b_clear_count got %0d exp 0", bus.count); end
    set_fields(4'd6, 5'd0, 5'd8, 5'd0, 16'hFFFF, 26'h0);
    @(negedge clk); v_valid = 1'b1;
    next_edge();
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_we1 got %b exp 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL b2b_addr1 got %h exp 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h2008_FFFF) begin n_fail++; $display("FAIL b2b_wdata1 got %h exp 2008ffff", bus.mem_wdata); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready1 got %b exp 0", bus.in_ready); end
    set_fields(4'd10, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
    next_edge();
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_we got %b exp 0", bus.mem_we); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got %b exp 0", bus.overflow); end
    next_edge();
    v_valid = 1'b0;
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_we2 got %b exp 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 32'h4) begin n_fail++; $display("FAIL b2b_addr2 got %h exp 4", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h8FA8_0004) begin n_fail++; $display("FAIL b2b_wdata2 got %h exp 8fa80004", bus.mem_wdata); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready2 got %b exp 0", bus.in_ready); end
    next_edge();
    n_checks++; if (bus.count !== 7'd2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", bus.count); end
  endtask

  task automatic test_jump_bgtz();
    set_fields(4'd15, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h000_0010);
    pulse_valid();
    n_checks++; if (bus.mem_addr !== 32'h8) begin n_fail++; $display("FAIL j_addr got %h exp 8", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h0800_0010) begin n_fail++; $display("FAIL j_wdata got %h exp 08000010", bus.mem_wdata); end
    next_edge();
    set_fields(4'd5, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h000_0010);
    pulse_valid();
    n_checks++; if (bus.mem_addr !== 32'hC) begin n_fail++; $display("FAIL jal_addr got %h exp c", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h0C00_0010) begin n_fail++; $display("FAIL jal_wdata got %h exp 0c000010", bus.mem_wdata); end
    next_edge();
    set_fields(4'd14, 5'd4, 5'd7, 5'd0, 16'h0003, 26'h0);
    pulse_valid();
    n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL bgtz_addr got %h exp 10", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h1C80_0003) begin n_fail++; $display("FAIL bgtz_wdata got %h exp 1c800003", bus.mem_wdata); end
    next_edge();
    n_checks++; if (bus.count !== 7'd5) begin n_fail++; $display("FAIL jmp_count got %0d exp 5", bus.count); end
  endtask

  task automatic test_all_ops();
    all_exp = '{32'h00A6_3820, 32'h00A6_3822, 32'h00A6_3824, 32'h00A6_3825,
                32'h00A6_382A, 32'h0EAB_CDEF, 32'h20A6_1234, 32'h34A6_1234,
                32'h30A6_1234, 32'h28A6_1234, 32'h8CA6_1234, 32'hACA6_1234,
                32'h10A6_1234, 32'h14A6_1234, 32'h1CA0_1234, 32'h0AAB_CDEF};
    pulse_clear();
    for (int i = 0; i < 16; i++) begin
      set_fields(4'(i), 5'd5, 5'd6, 5'd7, 16'h1234, 26'h2AB_CDEF);
      pulse_valid();
      n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL ops_we[%0d] got %b exp 1", i, bus.mem_we); end
      n_checks++; if (bus.mem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL ops_addr[%0d] got %h exp %h", i, bus.mem_addr, 32'(i * 4)); end
      n_checks++; if (bus.mem_wdata !== all_exp[i]) begin n_fail++; $display("FAIL ops_wdata[%0d] got %h exp %h", i, bus.mem_wdata, all_exp[i]); end
      next_edge();
    end
    n_checks++; if (bus.count !== 7'd16) begin n_fail++; $display("FAIL ops_count got %0d exp 16", bus.count); end
  endtask

  task automatic test_full_overflow();
    set_fields(4'd1, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0);
    for (int i = 0; i < 4; i++) begin
      pulse_valid4();
      n_checks++; if (bus4.mem_we !== 1'b1) begin n_fail++; $display("FAIL full_we[%0d] got %b exp 1", i, bus4.mem_we); end
      n_checks++; if (bus4.mem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL full_addr[%0d] got %h exp %h", i, bus4.mem_addr, 32'(i * 4)); end
      next_edge();
    end
    n_checks++; if (bus4.count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", bus4.count); end
    n_checks++; if (bus4.full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b exp 1", bus4.full); end
    n_checks++; if (bus4.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", bus4.in_ready); end
    n_checks++; if (bus4.overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf_pre got %b exp 0", bus4.overflow); end
    @(negedge clk); v_valid4 = 1'b1;
    next_edge();
    n_checks++; if (bus4.mem_we !== 1'b0) begin n_fail++; $display("FAIL ovf_we got %b exp 0", bus4.mem_we); end
    n_checks++; if (bus4.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", bus4.overflow); end
    next_edge();
    v_valid4 = 1'b0;
    n_checks++; if (bus4.mem_we !== 1'b0) begin n_fail++; $display("FAIL ovf_we2 got %b exp 0", bus4.mem_we); end
    n_checks++; if (bus4.count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", bus4.count); end
    @(negedge clk); v_clear4 = 1'b1;
    next_edge();
    v_clear4 = 1'b0;
    n_checks++; if (bus4.count !== 3'd0) begin n_fail++; $display("FAIL clr4_count got %0d exp 0", bus4.count); end
    n_checks++; if (bus4.overflow !== 1'b0) begin n_fail++; $display("FAIL clr4_ovf got %b exp 0", bus4.overflow); end
    n_checks++; if (bus4.full !== 1'b0) begin n_fail++; $display("FAIL clr4_full got %b exp 0", bus4.full); end
    n_checks++; if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL clr4_ready got %b exp 1", bus4.in_ready); end
    pulse_valid4();
    n_checks++; if (bus4.mem_addr !== 32'h0) begin n_fail++; $display("FAIL clr4_addr got %h exp 0", bus4.mem_addr); end
    n_checks++; if (bus4.mem_wdata !== 32'h012A_5822) begin n_fail++; $display("FAIL clr4_wdata got %h exp 012a5822", bus4.mem_wdata); end
    next_edge();
    n_checks++; if (bus4.count !== 3'd1) begin n_fail++; $display("FAIL clr4_count1 got %0d exp 1", bus4.count); end
  endtask

  task automatic test_clear_in_write();
    pulse_clear();
    set_fields(4'd3, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    for (int i = 0; i < 2; i++) begin
      pulse_valid();
      next_edge();
    end
    pulse_valid();
    v_clear = 1'b1;
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL cw_we got %b exp 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 32'h8) begin n_fail++; $display("FAIL cw_addr got %h exp 8", bus.mem_addr); end
    next_edge();
    v_clear = 1'b0;
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL cw_we_off got %b exp 0", bus.mem_we); end
    n_checks++; if (bus.count !== 7'd0) begin n_fail++; $display("FAIL cw_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL cw_addr_rst got %h exp 0", bus.mem_addr); end
    pulse_valid();
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL cw_next_addr got %h exp 0", bus.mem_addr); end
    next_edge();
    n_checks++; if (bus.count !== 7'd1) begin n_fail++; $display("FAIL cw_next_count got %0d exp 1", bus.count); end
  endtask

  task automatic test_reset_mid_write();
    set_fields(4'd2, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0);
    pulse_valid();
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rmw_we_pre got %b exp 1", bus.mem_we); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rmw_we got %b exp 0", bus.mem_we); end
    n_checks++; if (bus.count !== 7'd0) begin n_fail++; $display("FAIL rmw_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rmw_addr got %h exp 0", bus.mem_addr); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_ready got %b exp 1", bus.in_ready); end
    @(negedge clk); rst_n = 1'b1;
    next_edge();
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rmw_we_post got %b exp 0", bus.mem_we); end
    n_checks++; if (bus.count !== 7'd0) begin n_fail++; $display("FAIL rmw_count_post got %0d exp 0", bus.count); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    clk = 1'b0; rst_n = 1'b0;
    v_valid = 1'b0; v_valid4 = 1'b0; v_clear = 1'b0; v_clear4 = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    test_reset();
    test_add();
    test_back_to_back();
    test_jump_bgtz();
    test_all_ops();
    test_full_overflow();
    test_clear_in_write();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
